// File: rtl/vsi_ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vsi_ram_arbiter
//  Function : Round-robin arbiter sharing one single-port message RAM between
//             the RX byte writer and the TX byte reader, with TX read lock.
//  Revision : 1.0
// ============================================================================
module vsi_ram_arbiter #(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_h,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_rdy,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_rdy,
   input  logic              rd_lock,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] C_RD_LAT = 2'(RD_LATENCY);

   state_t            state_q, state_d;
   logic              last_rd_q, last_rd_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              ram_en_q, ram_en_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
   logic              wr_rdy_q, wr_rdy_d;
   logic              rd_rdy_q, rd_rdy_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              busy_q, busy_d;
   logic              grant_wr, grant_rd;

   always_comb begin
      state_d     = state_q;
      last_rd_d   = last_rd_q;
      cnt_d       = cnt_q;
      ram_en_d    = 1'b0;
      ram_we_d    = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      wr_rdy_d    = 1'b0;
      rd_rdy_d    = 1'b0;
      rd_data_d   = rd_data_q;
      grant_wr    = 1'b0;
      grant_rd    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // Contention: lock forces the reader, otherwise alternate.
            if (wr_req && rd_req) begin
               if (rd_lock || !last_rd_q) grant_rd = 1'b1;
               else                       grant_wr = 1'b1;
            end else begin
               grant_wr = wr_req;
               grant_rd = rd_req;
            end

            if (grant_wr) begin
               ram_en_d    = 1'b1;
               ram_we_d    = 1'b1;
               ram_addr_d  = wr_addr;
               ram_wdata_d = wr_data;
               last_rd_d   = 1'b0;
               state_d     = ST_WRITE;
            end else if (grant_rd) begin
               ram_en_d    = 1'b1;
               ram_addr_d  = rd_addr;
               last_rd_d   = 1'b1;
               cnt_d       = 2'd0;
               state_d     = ST_READ;
            end
         end
         ST_WRITE: begin
            wr_rdy_d = 1'b1;
            state_d  = ST_DONE;
         end
         ST_READ: begin
            // cnt_q counts cycles elapsed since the ram_en cycle.
            if (cnt_q == C_RD_LAT) begin
               rd_data_d = ram_rdata;
               rd_rdy_d  = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst_h) begin
         state_q     <= ST_IDLE;
         last_rd_q   <= 1'b1;
         cnt_q       <= 2'd0;
         ram_en_q    <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         wr_rdy_q    <= 1'b0;
         rd_rdy_q    <= 1'b0;
         rd_data_q   <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_rd_q   <= last_rd_d;
         cnt_q       <= cnt_d;
         ram_en_q    <= ram_en_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         wr_rdy_q    <= wr_rdy_d;
         rd_rdy_q    <= rd_rdy_d;
         rd_data_q   <= rd_data_d;
         busy_q      <= busy_d;
      end
   end

   assign ram_en    = ram_en_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_wdata = ram_wdata_q;
   assign wr_rdy    = wr_rdy_q;
   assign rd_rdy    = rd_rdy_q;
   assign rd_data   = rd_data_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_vsi_ram_arbiter.sv
`default_nettype none
// Directed bench for vsi_ram_arbiter: one instance with RD_LATENCY=1 backed
// by a RAM model, one with RD_LATENCY=3 for the reset-mid-read case.
module tb_vsi_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst, rst3;
   logic        wr_req, rd_req, rd_lock;
   logic [15:0] wr_addr, rd_addr;
   logic [7:0]  wr_data;
   logic        wr_rdy, rd_rdy, ram_en, ram_we, busy;
   logic [7:0]  rd_data, ram_wdata;
   logic [15:0] ram_addr;
   logic [7:0]  ram_rdata;

   logic        wr_req3, rd_req3, rd_lock3;
   logic [15:0] wr_addr3, rd_addr3;
   logic [7:0]  wr_data3;
   logic        wr_rdy3, rd_rdy3, ram_en3, ram_we3, busy3;
   logic [7:0]  rd_data3, ram_wdata3;
   logic [15:0] ram_addr3;
   logic [7:0]  ram_rdata3 = 8'h77;

   logic [7:0]  mem [0:63];
   int          checks = 0;
   int          errors = 0;
   int          n_wr, n_rd;

   always #5 clk = ~clk;

   vsi_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(1)) dut (
      .clk(clk), .rst_h(rst),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_rdy(rd_rdy),
      .rd_lock(rd_lock),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
   );

   vsi_ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LATENCY(3)) dut3 (
      .clk(clk), .rst_h(rst3),
      .wr_req(wr_req3), .wr_addr(wr_addr3), .wr_data(wr_data3), .wr_rdy(wr_rdy3),
      .rd_req(rd_req3), .rd_addr(rd_addr3), .rd_data(rd_data3), .rd_rdy(rd_rdy3),
      .rd_lock(rd_lock3),
      .ram_en(ram_en3), .ram_we(ram_we3), .ram_addr(ram_addr3),
      .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
   );

   // Single-port RAM with one cycle of read latency.
   always @(posedge clk) begin
      if (ram_en && ram_we)  mem[ram_addr[5:0]] <= ram_wdata;
      if (ram_en && !ram_we) ram_rdata <= mem[ram_addr[5:0]];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 8'h00;
      mem[4]    = 8'h3C;
      ram_rdata = 8'h00;
      rst = 1'b1; rst3 = 1'b1;
      wr_req = 0; rd_req = 0; rd_lock = 0; wr_addr = 0; rd_addr = 0; wr_data = 0;
      wr_req3 = 0; rd_req3 = 0; rd_lock3 = 0; wr_addr3 = 0; rd_addr3 = 0; wr_data3 = 0;
      tick(); tick();
      rst = 1'b0; rst3 = 1'b0;

      // Reset state
      chk("rst_outs", {ram_en, ram_we, wr_rdy, rd_rdy, busy}, 5'b0);
      chk("rst_addr", ram_addr, 16'h0);
      chk("rst_rdata", rd_data, 8'h0);
      chk("rst3_outs", {ram_en3, ram_we3, wr_rdy3, rd_rdy3, busy3, rd_data3}, 13'b0);

      // Single write
      wr_req = 1; wr_addr = 16'h0010; wr_data = 8'hA5;
      tick();
      chk("w1_en_we", {ram_en, ram_we, wr_rdy, busy}, 4'b1101);
      chk("w1_addr", ram_addr, 16'h0010);
      chk("w1_wdata", ram_wdata, 8'hA5);
      tick();
      chk("w1_rdy", {ram_en, wr_rdy, busy}, 3'b011);
      wr_req = 0;
      tick();
      chk("w1_idle", {ram_en, wr_rdy, busy}, 3'b000);

      // Single read of preloaded address 4
      rd_req = 1; rd_addr = 16'h0004;
      tick();
      chk("r1_en", {ram_en, ram_we, rd_rdy, busy}, 4'b1001);
      chk("r1_addr", ram_addr, 16'h0004);
      tick();
      chk("r1_wait", {ram_en, rd_rdy, busy}, 3'b001);
      tick();
      chk("r1_rdy", rd_rdy, 1'b1);
      chk("r1_data", rd_data, 8'h3C);
      rd_req = 0;
      tick();
      chk("r1_hold", {rd_rdy, busy, rd_data}, {2'b00, 8'h3C});

      // Round robin: both held, first grant goes to the write
      wr_req = 1; wr_addr = 16'h0020; wr_data = 8'h11;
      rd_req = 1; rd_addr = 16'h0010;
      for (int i = 1; i <= 14; i++) begin
         tick();
         chk("rr_en", ram_en, (i == 1 || i == 4 || i == 8 || i == 11));
         chk("rr_we", ram_en & ram_we, (i == 1 || i == 8));
         chk("rr_wrdy", wr_rdy, (i == 2 || i == 9));
         chk("rr_rrdy", rd_rdy, (i == 6 || i == 13));
         chk("rr_excl", wr_rdy & rd_rdy, 1'b0);
      end
      chk("rr_busy_end", busy, 1'b0);
      chk("rr_rdata", rd_data, 8'hA5);
      wr_req = 0; rd_req = 0;
      tick();

      // Read lock: reads monopolise the RAM while both request
      rd_lock = 1;
      wr_req = 1; wr_addr = 16'h0030; wr_data = 8'h99;
      rd_req = 1; rd_addr = 16'h0020;
      n_wr = 0; n_rd = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("lk_rrdy", rd_rdy, (i == 3 || i == 7 || i == 11));
         n_wr += int'(wr_rdy);
         n_rd += int'(rd_rdy);
      end
      chk("lk_nwr", n_wr, 0);
      chk("lk_nrd", n_rd, 3);
      chk("lk_rdata", rd_data, 8'h11);
      rd_lock = 0;
      tick();
      chk("lk_release", {ram_en, ram_we}, 2'b11);
      chk("lk_rel_addr", ram_addr, 16'h0030);
      tick();
      chk("lk_wrdy", {wr_rdy, rd_rdy}, 2'b10);
      wr_req = 0; rd_req = 0;
      tick();

      // Reset during the READ wait state of the latency-3 instance
      rd_req3 = 1; rd_addr3 = 16'h0008;
      tick();
      chk("rr3_en", {ram_en3, ram_we3}, 2'b10);
      tick();
      chk("rr3_wait", {ram_en3, rd_rdy3, busy3}, 3'b001);
      rst3 = 1;
      tick();
      chk("rr3_rst", {ram_en3, ram_we3, wr_rdy3, rd_rdy3, busy3, rd_data3}, 13'b0);
      chk("rr3_rst_addr", ram_addr3, 16'h0);
      rst3 = 0;
      wr_req3 = 1; wr_addr3 = 16'h0040; wr_data3 = 8'hC3;
      n_rd = 0;
      tick();
      chk("rr3_wfirst", {ram_en3, ram_we3}, 2'b11);
      chk("rr3_waddr", ram_addr3, 16'h0040);
      tick();
      chk("rr3_wrdy", {wr_rdy3, rd_rdy3}, 2'b10);
      wr_req3 = 0; rd_req3 = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_rd += int'(rd_rdy3);
      end
      chk("rr3_no_rrdy", n_rd, 0);

      // Write request dropped right after grant still commits once
      wr_req = 1; wr_addr = 16'h0004; wr_data = 8'h5A;
      tick();
      chk("dr_en", {ram_en, ram_we}, 2'b11);
      wr_req = 0;
      tick();
      chk("dr_rdy", {ram_en, wr_rdy}, 2'b01);
      n_wr = 0; n_rd = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_rd += int'(ram_en);
         n_wr += int'(wr_rdy);
      end
      chk("dr_no_en", n_rd, 0);
      chk("dr_one_rdy", n_wr, 0);
      chk("dr_busy", busy, 1'b0);
      rd_req = 1; rd_addr = 16'h0004;
      tick(); tick(); tick();
      chk("dr_readback", {rd_rdy, rd_data}, {1'b1, 8'h5A});
      rd_req = 0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
